naneye_config_tx: RTL

Manchester-encoding configuration transmitter that serializes sensor configuration words onto the sensor data line during the config phase, running on the same sample clock as the receive decoder. Each word is framed with a start marker, its bits are encoded as half-bit pairs, and the frame closes with a long low period. The receive-side decoder recognises this as an end-of-frame. It sits between the config register sequencer (valid/ready word source) and the bidirectional sensor pad (data plus output enable).

---
 rtl/naneye_config_tx.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/naneye_config_tx.sv
// naneye_config_tx: Manchester serializer for sensor configuration words on the bidirectional data pad.
// Latency: handshake in cycle t drives the start marker from cycle t+1; every half-bit is C_HALF_BIT_CYCLES cycles.
// Backpressure: TX_READY only in IDLE/WAIT (gated by ENABLE); WAIT holds the line low indefinitely.
// Optional feature macro: CONFIG_TX_PARITY_EN appends a Manchester-encoded odd-parity bit to every word.
module naneye_config_tx #(
    parameter int C_HALF_BIT_CYCLES = 9,
    parameter int C_HB_CNT_W        = 5,
    parameter int C_WORD_W          = 16,
    parameter int C_GAP_HALF_BITS   = 4,
    parameter int C_END_HALF_BITS   = 40,
    parameter int C_HB_IDX_W        = 8
) (
    input  logic                SCLOCK,
    input  logic                RESET,
    input  logic                ENABLE,
    input  logic [C_WORD_W-1:0] TX_DATA,
    input  logic                TX_VALID,
    input  logic                TX_LAST,
    output logic                TX_READY,
    output logic                SDATA_OUT,
    output logic                SDATA_OE,
    output logic                BUSY,
    output logic                DONE
);

`ifdef CONFIG_TX_PARITY_EN
    localparam int C_SH_W = C_WORD_W + 1;
`else
    localparam int C_SH_W = C_WORD_W;
`endif
    localparam int C_DATA_HB = 2 * C_SH_W;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_END   = 3'd5;

    localparam logic [C_HB_CNT_W-1:0] C_CNT_LAST   = C_HB_CNT_W'(C_HALF_BIT_CYCLES - 1);
    localparam logic [C_HB_IDX_W-1:0] C_IDX_START  = C_HB_IDX_W'(1);
    localparam logic [C_HB_IDX_W-1:0] C_IDX_DATA   = C_HB_IDX_W'(C_DATA_HB - 1);
    localparam logic [C_HB_IDX_W-1:0] C_IDX_GAP    = C_HB_IDX_W'(C_GAP_HALF_BITS - 1);
    localparam logic [C_HB_IDX_W-1:0] C_IDX_END    = C_HB_IDX_W'(C_END_HALF_BITS - 1);

    logic [2:0]            r_state;
    logic [C_HB_CNT_W-1:0] r_hb_cnt;
    logic [C_HB_IDX_W-1:0] r_hb_idx;
    logic [C_SH_W-1:0]     r_shift;
    logic                  r_last;
    logic                  r_sdata_out;
    logic                  r_sdata_oe;
    logic                  r_busy;
    logic                  r_done;

    logic [2:0]            w_nxt_state;
    logic [C_HB_CNT_W-1:0] w_nxt_cnt;
    logic [C_HB_IDX_W-1:0] w_nxt_idx;
    logic [C_SH_W-1:0]     w_nxt_shift;
    logic                  w_nxt_last;
    logic                  w_nxt_out;
    logic                  w_nxt_done;
    logic                  w_hb_wrap;
    logic                  w_handshake;
    logic [C_SH_W-1:0]     w_load;

    // Parity bit rides in the LSB of the shift register so it goes out right after the data bits.
`ifdef CONFIG_TX_PARITY_EN
    assign w_load = {TX_DATA, ~(^TX_DATA)};
`else
    assign w_load = TX_DATA;
`endif

    // Ready is combinational on state/ENABLE; RESET also gates it so it reads 0 while reset is held.
    assign TX_READY    = RESET && ENABLE && ((r_state == S_IDLE) || (r_state == S_WAIT));
    assign w_handshake = TX_VALID && TX_READY;
    assign w_hb_wrap   = (r_hb_cnt == C_CNT_LAST);

    // Next-state, half-bit counters and shift register; ENABLE low collapses everything to IDLE.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = w_hb_wrap ? '0 : r_hb_cnt + C_HB_CNT_W'(1);
        w_nxt_idx   = w_hb_wrap ? r_hb_idx + C_HB_IDX_W'(1) : r_hb_idx;
        w_nxt_shift = r_shift;
        w_nxt_last  = r_last;
        case (r_state)
            S_IDLE, S_WAIT: begin
                if (w_handshake) begin
                    w_nxt_state = S_START;
                    w_nxt_shift = w_load;
                    w_nxt_last  = TX_LAST;
                end
            end
            S_START: begin
                if (w_hb_wrap && (r_hb_idx == C_IDX_START)) w_nxt_state = S_DATA;
            end
            S_DATA: begin
                // Advance to the next bit after its second half-bit.
                if (w_hb_wrap && r_hb_idx[0]) w_nxt_shift = {r_shift[C_SH_W-2:0], 1'b0};
                if (w_hb_wrap && (r_hb_idx == C_IDX_DATA)) w_nxt_state = r_last ? S_END : S_GAP;
            end
            S_GAP: begin
                if (w_hb_wrap && (r_hb_idx == C_IDX_GAP)) w_nxt_state = S_WAIT;
            end
            S_END: begin
                if (w_hb_wrap && (r_hb_idx == C_IDX_END)) w_nxt_state = S_IDLE;
            end
            default: w_nxt_state = S_IDLE;
        endcase
        if (!ENABLE) begin
            w_nxt_state = S_IDLE;
            w_nxt_shift = '0;
            w_nxt_last  = 1'b0;
        end
        // Counters restart on every state entry and stay parked in the untimed states.
        if ((w_nxt_state != r_state) || (w_nxt_state == S_IDLE) || (w_nxt_state == S_WAIT)) begin
            w_nxt_cnt = '0;
            w_nxt_idx = '0;
        end
    end

    // Line value for the cycle being entered, so the registered output lines up with the state.
    always_comb begin
        w_nxt_out = 1'b0;
        case (w_nxt_state)
            S_START: w_nxt_out = 1'b1;
            S_DATA:  w_nxt_out = w_nxt_idx[0] ? w_nxt_shift[C_SH_W-1] : ~w_nxt_shift[C_SH_W-1];
            default: w_nxt_out = 1'b0;
        endcase
    end

    assign w_nxt_done = ENABLE && (r_state == S_END) && (w_nxt_state == S_IDLE);

    // State and registered pad outputs.
    always_ff @(posedge SCLOCK) begin
        if (!RESET) begin
            r_state     <= S_IDLE;
            r_hb_cnt    <= '0;
            r_hb_idx    <= '0;
            r_shift     <= '0;
            r_last      <= 1'b0;
            r_sdata_out <= 1'b0;
            r_sdata_oe  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_hb_cnt    <= w_nxt_cnt;
            r_hb_idx    <= w_nxt_idx;
            r_shift     <= w_nxt_shift;
            r_last      <= w_nxt_last;
            r_sdata_out <= w_nxt_out;
            r_sdata_oe  <= (w_nxt_state != S_IDLE);
            r_busy      <= (w_nxt_state != S_IDLE);
            r_done      <= w_nxt_done;
        end
    end

    assign SDATA_OUT = r_sdata_out;
    assign SDATA_OE  = r_sdata_oe;
    assign BUSY      = r_busy;
    assign DONE      = r_done;

endmodule
